// File: rtl/hp_mul_seq.sv
// hp_mul_seq: iterative bfloat16-format floating-point multiplier.
//
// The significands are multiplied one multiplier bit per cycle (shift-add).
// The product is then normalized, rounded to nearest-even and range checked.
// Subnormal operands are treated as zero, and results that fall below the
// normal range flush to signed zero.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (aborts any operation in flight)
//   in_valid   operand pair a/b is valid
//   in_ready   block is idle and can accept operands
//   a, b       operands {sign, exp, frac}
//   out_valid  p/bfFlags/exception hold a result
//   out_ready  consumer accepts the result
//   p          product
//   bfFlags    one-hot class of p {snan, qnan, inf, zero, subnormal, normal}
//   exception  {invalid, divbyzero, overflow, underflow, inexact}
module hp_mul_seq #(
    parameter int NEXP = 8,
    parameter int NSIG = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NEXP+NSIG:0]   a,
    input  logic [NEXP+NSIG:0]   b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NEXP+NSIG:0]   p,
    output logic [5:0]           bfFlags,
    output logic [4:0]           exception
);

    localparam int W  = NEXP + NSIG + 1;   // word width
    localparam int SW = NSIG + 1;          // significand width incl. hidden bit
    localparam int PW = 2 * SW;            // full product width
    localparam int EW = NEXP + 2;          // signed exponent intermediate
    localparam int CW = $clog2(SW);        // step counter width

    localparam logic signed [EW-1:0] BIAS = EW'((1 << (NEXP - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX = EW'((1 << NEXP) - 1);
    localparam logic [W-1:0] QNAN = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t state, state_nxt;

    logic [SW-1:0]        ma, mb;
    logic                 sgn;
    logic signed [EW-1:0] exp_sum;
    logic [PW-1:0]        acc;
    logic [CW-1:0]        cnt;
    logic [W-1:0]         res_p;
    logic [4:0]           res_exc;

    // ------------------------------------------------------------------
    // Operand classification (only meaningful while IDLE)
    // ------------------------------------------------------------------
    logic [NEXP-1:0] ea, eb;
    logic [NSIG-1:0] fa, fb;
    logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero, sgn_in;

    assign ea     = a[W-2 -: NEXP];
    assign eb     = b[W-2 -: NEXP];
    assign fa     = a[NSIG-1:0];
    assign fb     = b[NSIG-1:0];
    assign a_nan  = (&ea) && (|fa);
    assign b_nan  = (&eb) && (|fb);
    assign a_snan = a_nan && !fa[NSIG-1];
    assign b_snan = b_nan && !fb[NSIG-1];
    assign a_inf  = (&ea) && !(|fa);
    assign b_inf  = (&eb) && !(|fb);
    // Subnormals count as zero here (denormals-are-zero).
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign sgn_in = a[W-1] ^ b[W-1];

    logic           spec_hit;
    logic [W-1:0]   spec_p;
    logic [4:0]     spec_exc;

    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        spec_hit = 1'b1;
        spec_p   = QNAN;
        spec_exc = '0;
        if (a_snan || b_snan) begin
            spec_exc = 5'b10000;
        end else if (a_nan || b_nan) begin
            spec_exc = '0;
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            spec_exc = 5'b10000;
        end else if (a_inf || b_inf) begin
            spec_p = {sgn_in, {NEXP{1'b1}}, {NSIG{1'b0}}};
        end else if (a_zero || b_zero) begin
            spec_p = {sgn_in, {(W-1){1'b0}}};
        end else begin
            spec_hit = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Normalize / round / range check of the finished product
    // ------------------------------------------------------------------
    logic                 top, guard, sticky, rnd_up;
    logic [NSIG-1:0]      frac;
    logic [SW-1:0]        frac_rnd;
    logic signed [EW-1:0] exp_fin;
    logic [W-1:0]         norm_p;
    logic [4:0]           norm_exc;

    always_comb begin
        // Product of two [1,2) significands lies in [1,4); top marks [2,4).
        top    = acc[PW-1];
        frac   = top ? acc[PW-2 -: NSIG]  : acc[PW-3 -: NSIG];
        guard  = top ? acc[PW-2-NSIG]     : acc[PW-3-NSIG];
        sticky = top ? |acc[PW-3-NSIG:0]  : |acc[PW-4-NSIG:0];
        rnd_up = guard && (sticky || frac[0]);
        frac_rnd = {1'b0, frac} + {{NSIG{1'b0}}, rnd_up};
        // A rounding carry leaves the fraction field zero and bumps the exponent.
        exp_fin = exp_sum
                + $signed({{(EW-1){1'b0}}, top})
                + $signed({{(EW-1){1'b0}}, frac_rnd[NSIG]});
        norm_p   = {sgn, exp_fin[NEXP-1:0], frac_rnd[NSIG-1:0]};
        norm_exc = {4'b0000, guard || sticky};
        if (exp_fin >= EMAX) begin
            norm_p   = {sgn, {NEXP{1'b1}}, {NSIG{1'b0}}};
            norm_exc = 5'b00101;
        end else if (exp_fin[EW-1] || (exp_fin == '0)) begin
            norm_p   = {sgn, {(W-1){1'b0}}};
            norm_exc = 5'b00011;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        p         = '0;
        exception = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = spec_hit ? DONE : MUL;
            end
            MUL:  if (cnt == CW'(NSIG)) state_nxt = NORM;
            NORM: state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                p         = res_p;
                exception = res_exc;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    function automatic logic [5:0] classify(input logic [W-1:0] x);
        logic [5:0] c;
        if (&x[W-2 -: NEXP]) begin
            if (x[NSIG-1:0] == '0) c = 6'b001000;
            else if (x[NSIG-1])    c = 6'b010000;
            else                   c = 6'b100000;
        end else if (x[W-2 -: NEXP] == '0) begin
            c = (x[NSIG-1:0] == '0) ? 6'b000100 : 6'b000010;
        end else begin
            c = 6'b000001;
        end
        return c;
    endfunction

    // Flags always describe what p currently shows (zero while not DONE).
    always_comb bfFlags = classify(p);

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ma      <= '0;
            mb      <= '0;
            sgn     <= 1'b0;
            exp_sum <= '0;
            acc     <= '0;
            cnt     <= '0;
            res_p   <= '0;
            res_exc <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    ma      <= {1'b1, fa};
                    mb      <= {1'b1, fb};
                    sgn     <= sgn_in;
                    exp_sum <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
                    acc     <= '0;
                    cnt     <= '0;
                    // Special results are final; normal ones are overwritten in NORM.
                    res_p   <= spec_p;
                    res_exc <= spec_exc;
                end
                MUL: begin
                    if (mb[cnt]) acc <= acc + (PW'(ma) << cnt);
                    cnt <= cnt + 1'b1;
                end
                NORM: begin
                    res_p   <= norm_p;
                    res_exc <= norm_exc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hp_mul_seq.sv
// Self-checking bench for hp_mul_seq: directed vectors with hand-computed
// results, backpressure and mid-operation reset, then randomized operands
// checked against an arithmetic reference model.
module tb_hp_mul_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready;
    logic        in_ready, out_valid;
    logic [15:0] a = '0, b = '0, p;
    logic [5:0]  fl;
    logic [4:0]  ex;

    hp_mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .bfFlags   (fl),
        .exception (ex)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] p;
        logic [5:0]  fl;
        logic [4:0]  ex;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    bit   front_seen = 1'b0;
    bit   rand_bp    = 1'b0;
    bit   hold_ready = 1'b1;

    // Single driver of out_ready, updated just after each rising edge.
    always @(posedge clk) begin
        #2;
        out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : hold_ready;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic logic [5:0] cls(input logic [15:0] x);
        if (x[14:7] == 8'hFF) return (x[6:0] == 7'h0) ? 6'b001000 : (x[6] ? 6'b010000 : 6'b100000);
        if (x[14:7] == 8'h00) return (x[6:0] == 7'h0) ? 6'b000100 : 6'b000010;
        return 6'b000001;
    endfunction

    // Reference model: returns {exception, p}.
    function automatic logic [20:0] model(input logic [15:0] x, input logic [15:0] y);
        int ex_, ey_, fx, fy, prod, e, sh, q, rem, half;
        bit s, xnan, ynan, xsn, ysn, xinf, yinf, xz, yz, inx;
        ex_ = int'(x[14:7]);  fx = int'(x[6:0]);
        ey_ = int'(y[14:7]);  fy = int'(y[6:0]);
        s    = x[15] ^ y[15];
        xnan = (ex_ == 255) && (fx != 0);   ynan = (ey_ == 255) && (fy != 0);
        xsn  = xnan && (fx < 64);           ysn  = ynan && (fy < 64);
        xinf = (ex_ == 255) && (fx == 0);   yinf = (ey_ == 255) && (fy == 0);
        xz   = (ex_ == 0);                  yz   = (ey_ == 0);
        if (xsn || ysn)                   return {5'b10000, 16'h7FC0};
        if (xnan || ynan)                 return {5'b00000, 16'h7FC0};
        if ((xinf && yz) || (yinf && xz)) return {5'b10000, 16'h7FC0};
        if (xinf || yinf)                 return {5'b00000, s, 8'hFF, 7'h00};
        if (xz || yz)                     return {5'b00000, s, 15'h0000};
        prod = (128 + fx) * (128 + fy);
        e    = ex_ + ey_ - 127;
        sh   = 7;
        if (prod >= 32768) begin
            sh = 8;
            e  = e + 1;
        end
        q    = prod >> sh;
        rem  = prod - (q << sh);
        half = 1 << (sh - 1);
        inx  = (rem != 0);
        if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
        if (q == 256) begin
            q = 128;
            e = e + 1;
        end
        if (e >= 255) return {5'b00101, s, 8'hFF, 7'h00};
        if (e <= 0)   return {5'b00011, s, 15'h0000};
        return {4'b0000, inx, s, 8'(e), 7'(q)};
    endfunction

    function automatic int lat_of(input logic [15:0] x, input logic [15:0] y);
        bit sp;
        sp = (x[14:7] == 8'hFF) || (x[14:7] == 8'h00) || (y[14:7] == 8'hFF) || (y[14:7] == 8'h00);
        return sp ? 1 : 10;
    endfunction

    // Compare process: every cycle out of reset, the outputs are either an idle
    // zero result or the oldest outstanding expected result.
    always @(negedge clk) begin
        if (!rst) begin
            if (sb.size() == 0) front_seen = 1'b0;
            if (out_valid) begin
                check("busy_in_ready", 32'(in_ready), 32'd0);
                if (sb.size() == 0) begin
                    check("pending_results", 32'(sb.size()), 32'd1);
                end else begin
                    if (!front_seen) begin
                        check("latency", 32'(cyc + 1 - sb[0].acc), 32'(sb[0].lat));
                        front_seen = 1'b1;
                    end
                    check("p", 32'(p), 32'(sb[0].p));
                    check("bfFlags", 32'(fl), 32'(sb[0].fl));
                    check("exception", 32'(ex), 32'(sb[0].ex));
                    if (out_ready) begin
                        void'(sb.pop_front());
                        front_seen = 1'b0;
                    end
                end
            end else if (in_ready) begin
                check("idle_p", 32'(p), 32'd0);
                check("idle_flags", 32'(fl), 32'b000100);
                check("idle_exc", 32'(ex), 32'd0);
            end
        end
    end

    task automatic send(input logic [15:0] xa, input logic [15:0] xb,
                        input logic [15:0] ep, input logic [5:0] ef, input logic [4:0] ee);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            return;
        end
        a = xa;
        b = xb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        e.p   = ep;
        e.fl  = ef;
        e.ex  = ee;
        e.lat = lat_of(xa, xb);
        e.acc = cyc;
        sb.push_back(e);
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
    endtask

    // Directed vector: pins the model to a hand-computed result, then sends it.
    task automatic dir(input logic [15:0] xa, input logic [15:0] xb,
                       input logic [15:0] ep, input logic [5:0] ef, input logic [4:0] ee);
        logic [20:0] m;
        m = model(xa, xb);
        check("model_pin_p", 32'(m[15:0]), 32'(ep));
        check("model_pin_exc", 32'(m[20:16]), 32'(ee));
        check("model_pin_flags", 32'(cls(m[15:0])), 32'(ef));
        send(xa, xb, ep, ef, ee);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    function automatic logic [15:0] gen_op();
        logic [7:0] e;
        logic [6:0] f;
        int k;
        k = $urandom_range(0, 15);
        f = 7'($urandom);
        case (k)
            0:       begin e = 8'h00; f = 7'h00; end
            1:       begin e = 8'h00; f = f | 7'h01; end
            2:       begin e = 8'hFF; f = 7'h00; end
            3:       begin e = 8'hFF; f = {1'b1, f[5:0]}; end
            4:       begin e = 8'hFF; f = {1'b0, f[5:0] | 6'h01}; end
            5:       e = 8'($urandom_range(230, 254));
            6:       e = 8'($urandom_range(1, 30));
            default: e = 8'($urandom_range(90, 165));
        endcase
        return {1'($urandom), e, f};
    endfunction

    function automatic bit inf_sub(input logic [15:0] x, input logic [15:0] y);
        return (x[14:0] == 15'h7F80) && (y[14:7] == 8'h00) && (y[6:0] != 7'h00);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] x, y;
        logic [20:0] m;
        int n;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_p", 32'(p), 32'd0);
        check("rst_flags", 32'(fl), 32'b000100);
        check("rst_exc", 32'(ex), 32'd0);
        rst = 1'b0;

        // Directed vectors, consumer always ready
        dir(16'h3FC0, 16'h4000, 16'h4040, 6'b000001, 5'b00000);
        dir(16'h3F81, 16'h3F81, 16'h3F82, 6'b000001, 5'b00001);
        dir(16'h7F80, 16'h0000, 16'h7FC0, 6'b010000, 5'b10000);
        dir(16'h7F81, 16'h3F80, 16'h7FC0, 6'b010000, 5'b10000);
        dir(16'h7F00, 16'h4000, 16'h7F80, 6'b001000, 5'b00101);
        dir(16'h0080, 16'h3F00, 16'h0000, 6'b000100, 5'b00011);
        dir(16'h3F81, 16'h3FC0, 16'h3FC2, 6'b000001, 5'b00001);  // tie, rounds to even (up)
        dir(16'h3FB5, 16'h3FB5, 16'h4000, 6'b000001, 5'b00001);  // rounding carry
        dir(16'h3FFF, 16'h3FFF, 16'h407E, 6'b000001, 5'b00001);  // product >= 2
        dir(16'hFF80, 16'h4000, 16'hFF80, 6'b001000, 5'b00000);
        dir(16'h8000, 16'h3F80, 16'h8000, 6'b000100, 5'b00000);
        dir(16'h0001, 16'h3F80, 16'h0000, 6'b000100, 5'b00000);  // subnormal as zero
        dir(16'h3F80, 16'hFFC0, 16'h7FC0, 6'b010000, 5'b00000);
        drain();

        // Backpressure: result held, a second request is ignored
        hold_ready = 1'b0;
        @(posedge clk);
        #3;
        send(16'h3F81, 16'h3F81, 16'h3F82, 6'b000001, 5'b00001);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b1;
        a = 16'h4000;
        b = 16'h4000;
        repeat (5) @(negedge clk);
        check("bp_still_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        hold_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        repeat (4) @(negedge clk);
        check("bp_no_extra", 32'(sb.size()), 32'd0);

        // Reset during MUL aborts the operation
        send(16'h3FC0, 16'h4000, 16'h4040, 6'b000001, 5'b00000);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        repeat (12) @(negedge clk);
        dir(16'hC000, 16'h4040, 16'hC0C0, 6'b000001, 5'b00000);
        drain();

        // Randomized operands with random consumer backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            x = gen_op();
            y = gen_op();
            while (inf_sub(x, y) || inf_sub(y, x)) begin
                x = gen_op();
                y = gen_op();
            end
            m = model(x, y);
            send(x, y, m[15:0], cls(m[15:0]), m[20:16]);
        end
        rand_bp = 1'b0;
        hold_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
